// File: rtl/byte_link_pkg.sv
// Shared definitions for the byte link: FSM state encoding and frame constants.
// Used by both the transmitter and the matching receiver.
package byte_link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // One start bit, eight data bits and one stop bit.
  localparam int   FRAME_BITS = 10;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/byte_serial_tx_if.sv
// Load/status bundle between a word producer and the byte serial transmitter.
// enable is a one-cycle load strobe and is taken only while busy is low; a strobe
// seen while busy is high is dropped, so the producer must wait for busy to fall.
interface byte_serial_tx_if #(
    parameter int DATA_W = 8
);
    logic              enable;
    logic [DATA_W-1:0] d;
    logic              tx;
    logic              busy;
    logic              done;
    logic              zero_flag;

    modport master (
        output enable,
        output d,
        input  tx,
        input  busy,
        input  done,
        input  zero_flag
    );

    modport slave (
        input  enable,
        input  d,
        output tx,
        output busy,
        output done,
        output zero_flag
    );
endinterface

// File: rtl/bit_timer.sv
// Free-running bit-period counter; tick marks the last cycle of each serial bit.
// clear holds the count at zero so a new frame always starts on a full period.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/byte_serial_tx.sv
// Parallel-load, LSB-first serial transmitter with start/stop framing.
// All outputs are registered; the FSM state is exported on dbg_state.
module byte_serial_tx
    import byte_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    byte_serial_tx_if.slave   bus,
    output tx_state_t         dbg_state
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shift_reg;
    logic [IDX_W-1:0]  bit_idx;
    logic              tx_r;
    logic              busy_r;
    logic              done_r;
    logic              zero_r;
    logic              tick;
    logic              timer_clear;

    // Holding the timer in IDLE makes the load edge the start of bit period zero.
    assign timer_clear = (state == IDLE);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx_r      <= IDLE_LEVEL;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            zero_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    tx_r   <= IDLE_LEVEL;
                    busy_r <= 1'b0;
                    if (bus.enable) begin
                        shift_reg <= bus.d;
                        zero_r    <= (bus.d == '0);
                        bit_idx   <= '0;
                        tx_r      <= 1'b0;
                        busy_r    <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_r    <= shift_reg[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
                            tx_r  <= IDLE_LEVEL;
                            state <= STOP;
                        end else begin
                            // tx is registered, so it takes the bit that is about to shift into [0].
                            shift_reg <= shift_reg >> 1;
                            tx_r      <= shift_reg[1];
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    tx_r   <= IDLE_LEVEL;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx        = tx_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.zero_flag = zero_r;
    assign dbg_state     = state;
endmodule

// File: tb/tb_byte_serial_tx.sv
// Bench for byte_serial_tx: directed scenarios plus random traffic, every cycle
// compared against a waveform-queue reference model.
module tb_byte_serial_tx;
  import byte_link_pkg::*;

  localparam int CPB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  byte_serial_tx_if #(.DATA_W(8)) bus();
  tx_state_t dbg_state;

  byte_serial_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // scoreboard: one expected tx level per upcoming cycle of the current frame
  logic exp_q[$];
  logic exp_done;
  logic exp_zero;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  int   frames_exp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: update the model with the inputs seen at the edge, then compare.
  task automatic step();
    logic       en_s;
    logic       rst_s;
    logic [7:0] d_s;
    logic       was_busy;
    logic       bit_v;
    en_s  = bus.enable;
    rst_s = rst_n;
    d_s   = bus.d;
    @(posedge clk);
    if (!rst_s) begin
      exp_q.delete();
      exp_done = 1'b0;
      exp_zero = 1'b0;
    end else begin
      was_busy = (exp_q.size() != 0);
      exp_done = 1'b0;
      if (was_busy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          exp_done = 1'b1;
          frames_exp++;
        end
      end
      if (!was_busy && en_s) begin
        exp_zero = (d_s == 8'h00);
        for (int b = 0; b < FRAME_BITS; b++) begin
          if (b == 0) bit_v = 1'b0;
          else if (b == FRAME_BITS - 1) bit_v = 1'b1;
          else bit_v = d_s[b-1];
          for (int c = 0; c < CPB; c++) exp_q.push_back(bit_v);
        end
      end
    end
    #1;
    check("tx", 32'(bus.tx), 32'((exp_q.size() != 0) ? exp_q[0] : 1'b1));
    check("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
    check("done", 32'(bus.done), 32'(exp_done));
    check("zero_flag", 32'(bus.zero_flag), 32'(exp_zero));
    if (bus.done === 1'b1) done_seen++;
  endtask

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [7:0] val);
    bus.enable = 1'b1;
    bus.d      = val;
    step();
    bus.enable = 1'b0;
    bus.d      = 8'($urandom);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.d      = 8'h00;

    // 1: reset then idle
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(5);

    // 2: A5 frame
    load(8'hA5);
    idle(45);

    // 3: zero word, then 01 clears the flag
    load(8'h00);
    idle(42);
    load(8'h01);
    idle(42);

    // 4: strobe during a frame is ignored
    load(8'h3C);
    idle(9);
    load(8'hFF);
    idle(40);

    // 5: back-to-back load in the done cycle
    load(8'hC3);
    begin
      int budget;
      budget = 0;
      while (bus.done !== 1'b1 && budget < 100) begin
        step();
        budget++;
      end
      check("done_wait", 32'(bus.done), 32'd1);
    end
    load(8'h5A);
    idle(45);

    // 6: reset during data bit 3 aborts without done
    load(8'h96);
    idle(17);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(45);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bus.enable = ($urandom_range(0, 3) == 0);
      bus.d      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rst_n      = ($urandom_range(0, 299) != 0);
      step();
    end
    bus.enable = 1'b0;
    rst_n = 1'b1;
    idle(45);

    check("done_count", 32'(done_seen), 32'(frames_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
